decode_stage: RTL
=================

# decode_stage

Second pipeline stage of the RV32I core. It latches the fetched instruction and `pc_4` into an IF/ID register with stall and flush control. It holds the 32-entry integer register file with a write-back port and same-cycle bypass, and decodes the latched instruction into operands, a sign-extended immediate and control fields for the execute stage.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `NOP_INST`, 32'h0000_0013, instruction value loaded on reset or flush (`addi x0,x0,0`)

Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; sampled on `clock` rising edge
- `stall`  in  1  hold IF/ID register contents
- `flush`  in  1  replace IF/ID contents with a bubble
- `instruction_in`  in  32  instruction from fetch stage
- `pc_4_in`  in  32  fetch PC + 4
- `wb_en`  in  1  register write enable from write-back
- `wb_rd`  in  5  write-back destination register
- `wb_data`  in  32  write-back data
- `valid_out`  out  1  latched instruction is live
- `pc_out`, `pc_4_out`  out  32  instruction PC (`pc_4 - 4`, modulo 2^32) and PC + 4
- `rs1_addr`, `rs2_addr`, `rd_addr`  out  5  register fields [19:15], [24:20], [11:7]
- `rs1_data`, `rs2_data`  out  32  operand values after bypass
- `imm`  out  32  sign-extended immediate
- `alu_op`  out  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 PASSB=10
- `alu_src_imm`, `alu_src_pc`  out  1  ALU B = `imm`; ALU A = `pc_out`
- `mem_op`  out  2  00 none, 01 read, 10 write
- `mem_funct3`  out  3  instruction [14:12]
- `reg_write`  out  1  result written to `rd`
- `wb_sel`  out  2  0 ALU, 1 memory, 2 `pc_4`
- `branch`, `jump`, `jalr`  out  1  control-flow class
- `illegal`  out  1  unrecognised encoding

## Operation
IF/ID register. Priority is reset > flush > stall > load.
- reset or flush: inst ← `NOP_INST`, pc_4 ← 0, valid ← 0.
- stall: all fields hold.
- otherwise: capture `instruction_in` and `pc_4_in`; valid ← 1.

Register file: 32×32 entries.
- Reset clears all entries to 0.
- x0 reads 0 always; writes to x0 are dropped.
- Write on the clock edge when `wb_en && wb_rd != 0` and not reset. Writes are independent of stall and flush.
- Read addresses come from the latched instruction.
- Bypass: if `wb_en && wb_rd == rsN && rsN != 0`, `rsN_data = wb_data` in the same cycle.

Decode is combinational from the IF/ID register.
- Opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- Immediates (bit 31 sign-extends):
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
- Controls per opcode:
  - LUI: PASSB, imm, reg_write, wb 0.
  - AUIPC: ADD, src_pc, src_imm, reg_write.
  - JAL: jump, reg_write, wb 2, ADD with src_pc and src_imm.
  - JALR: jump, jalr, reg_write, wb 2, ADD with src_imm.
  - BRANCH: branch, SUB.
  - LOAD: mem_op 01, ADD with src_imm, reg_write, wb 1.
  - STORE: mem_op 10, ADD with src_imm.
  - OP/OP-IMM: alu_op from funct3/funct7[5].
- OP-IMM has no SUB.
- SRAI uses funct7 0100000; any other funct7 on shifts is illegal.
- `illegal` is asserted for unknown opcodes and for these invalid funct3 values: BRANCH 010/011, LOAD 011/110/111, STORE ≥011, JALR ≠000.
- When `!valid_out || illegal`, the outputs are forced to: `reg_write`=0, `mem_op`=00, `branch`=`jump`=`jalr`=0. `illegal` is suppressed when `!valid_out`.

## Timing
- Latency: fetch outputs appear at decode outputs one cycle after capture. All outputs are combinational from IF/ID state, the register file and the write-back port.
- Reset values:
  - `valid_out`=0.
  - Decode of `NOP_INST` gives `imm`=0, `alu_op`=ADD, `alu_src_imm`=1, all control outputs 0.
  - `rs*_data`=0, `pc_4_out`=0, `pc_out`=32'hFFFF_FFFC.
- Flush and stall in the same cycle: flush wins.
- A write-back in a stalled cycle updates the register file. The bypass makes the new value visible on the same cycle.
- `wb_en` asserted during reset: the write is discarded.
- Write and read of the same register in the same cycle return `wb_data`, never the stale value.

## Test plan
- Reset, then load `addi x1,x0,5` (32'h0050_0093) with `pc_4_in`=8 → next cycle: `valid_out`=1, `pc_out`=4, `imm`=5, `rd_addr`=1, `reg_write`=1, `alu_op`=ADD.
- `wb_en`=1, `wb_rd`=3, `wb_data`=32'hDEAD_BEEF while the latched instruction reads rs1=x3 → `rs1_data`=32'hDEAD_BEEF that cycle and on later reads. `wb_rd`=0 with `wb_data`=7 → x0 still reads 0.
- Load `beq` with offset -4 (32'hFE00_0EE3) → `branch`=1, `imm`=32'hFFFF_FFFC, `alu_op`=SUB, `reg_write`=0.
- Assert `stall` for 3 cycles while `instruction_in` changes → outputs hold. Then assert `flush` and `stall` together → `valid_out`=0, `reg_write`=0, `mem_op`=00.
- Load opcode 7'b1111111 → `illegal`=1 and all side-effect controls 0. Load SRAI with funct7 0100000 and shamt 3 → `alu_op`=SRA, `imm`[4:0]=3.
- Assert `reset` for one cycle mid-stream with `wb_en`=1 → all registers read 0, `valid_out`=0 next cycle.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, 32x32 register file with write-back bypass, instruction decode.
// Outputs are combinational from IF/ID state and regfile, one cycle after capture; stall holds and flush bubbles the register.
module decode_stage #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [31:0]     instruction_in,
  input  logic [XLEN-1:0] pc_4_in,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            valid_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_4_out,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [31:0]     imm,
  output logic [3:0]      alu_op,
  output logic            alu_src_imm,
  output logic            alu_src_pc,
  output logic [1:0]      mem_op,
  output logic [2:0]      mem_funct3,
  output logic            reg_write,
  output logic [1:0]      wb_sel,
  output logic            branch,
  output logic            jump,
  output logic            jalr,
  output logic            illegal
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5,
    ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
  } alu_op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [31:0]     inst_q;
  logic [XLEN-1:0] pc4_q;
  logic            valid_q;
  logic [XLEN-1:0] rf_q [32];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      inst_q  <= NOP_INST;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      inst_q  <= instruction_in;
      pc4_q   <= pc_4_in;
      valid_q <= 1'b1;
    end
  end

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  assign valid_out  = valid_q;
  assign pc_4_out   = pc4_q;
  assign pc_out     = pc4_q - XLEN'(4);
  assign rs1_addr   = inst_q[19:15];
  assign rs2_addr   = inst_q[24:20];
  assign rd_addr    = inst_q[11:7];
  assign mem_funct3 = inst_q[14:12];

  always_comb begin
    rs1_data = rf_q[rs1_addr];
    rs2_data = rf_q[rs2_addr];
    if (rs1_addr == 5'd0) rs1_data = '0;
    else if (wb_en && wb_rd == rs1_addr) rs1_data = wb_data;
    if (rs2_addr == 5'd0) rs2_data = '0;
    else if (wb_en && wb_rd == rs2_addr) rs2_data = wb_data;
  end

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        ill_raw;

  assign opcode = inst_q[6:0];
  assign f3     = inst_q[14:12];
  assign f7     = inst_q[31:25];
  assign imm_i  = {{20{inst_q[31]}}, inst_q[31:20]};
  assign imm_s  = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
  assign imm_b  = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign imm_u  = {inst_q[31:12], 12'b0};
  assign imm_j  = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};

  always_comb begin
    imm         = '0;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    alu_src_pc  = 1'b0;
    mem_op      = 2'b00;
    reg_write   = 1'b0;
    wb_sel      = 2'd0;
    branch      = 1'b0;
    jump        = 1'b0;
    jalr        = 1'b0;
    ill_raw     = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OPC_LUI:   begin imm = imm_u; alu_op = ALU_PASSB; alu_src_imm = 1'b1; reg_write = 1'b1; end
      OPC_AUIPC: begin imm = imm_u; alu_src_imm = 1'b1; alu_src_pc = 1'b1; reg_write = 1'b1; end
      OPC_JAL: begin
        imm = imm_j; alu_src_imm = 1'b1; alu_src_pc = 1'b1;
        jump = 1'b1; reg_write = 1'b1; wb_sel = 2'd2;
      end
      OPC_JALR: begin
        imm = imm_i; alu_src_imm = 1'b1; jump = 1'b1; jalr = 1'b1;
        reg_write = 1'b1; wb_sel = 2'd2; ill_raw = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        imm = imm_b; alu_op = ALU_SUB; branch = 1'b1;
        ill_raw = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        imm = imm_i; alu_src_imm = 1'b1; mem_op = 2'b01; reg_write = 1'b1; wb_sel = 2'd1;
        ill_raw = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin imm = imm_s; alu_src_imm = 1'b1; mem_op = 2'b10; ill_raw = (f3 >= 3'b011); end
      OPC_OPIMM, OPC_OP: begin
        if (opcode == OPC_OPIMM) begin
          imm = imm_i;
          alu_src_imm = 1'b1;
        end
        reg_write = 1'b1;
        case (f3)
          3'b000: alu_op = (opcode == OPC_OP && f7[5]) ? ALU_SUB : ALU_ADD;
          3'b001: begin alu_op = ALU_SLL; ill_raw = (f7 != 7'b0000000); end
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: begin
            alu_op  = f7[5] ? ALU_SRA : ALU_SRL;
            ill_raw = (f7 != 7'b0000000) && (f7 != 7'b0100000);
          end
          3'b110: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      default: ill_raw = 1'b1;
    endcase
    // Bubbles and bad encodings must not cause architectural side effects downstream.
    if (!valid_q || ill_raw) begin
      reg_write = 1'b0;
      mem_op    = 2'b00;
      branch    = 1'b0;
      jump      = 1'b0;
      jalr      = 1'b0;
    end
    illegal = valid_q && ill_raw;
  end

endmodule
